// File: rtl/cmd_fifo_responder_pkg.sv
// Shared types and command-field layout for the command FIFO responder.
package cmd_fifo_responder_pkg;

  localparam int CMD_W    = 17;
  localparam int OP_BIT   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Which byte the RESP state presents to the response FIFO.
  typedef enum logic [1:0] {
    RSEL_RDATA = 2'd0,
    RSEL_ACK   = 2'd1,
    RSEL_ERR   = 2'd2
  } resp_sel_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo_responder_if.sv
// Command-FIFO read port and response-FIFO write port seen by the responder.
interface cmd_fifo_responder_if;
  import cmd_fifo_responder_pkg::*;

  logic             cmd_fifo_rd_en;
  logic [CMD_W-1:0] cmd_fifo_data;
  logic             cmd_fifo_empty;
  logic             resp_fifo_wr_en;
  logic [7:0]       resp_fifo_data;
  logic             resp_fifo_full;

  // Responder side: pops commands and pushes responses.
  modport master (
    output cmd_fifo_rd_en,
    input  cmd_fifo_data,
    input  cmd_fifo_empty,
    output resp_fifo_wr_en,
    output resp_fifo_data,
    input  resp_fifo_full
  );

  // FIFO side.
  modport slave (
    input  cmd_fifo_rd_en,
    output cmd_fifo_data,
    output cmd_fifo_empty,
    input  resp_fifo_wr_en,
    input  resp_fifo_data,
    output resp_fifo_full
  );

endinterface

// File: rtl/cmd_fifo_responder_regfile.sv
// Single-port byte RAM: synchronous write, registered read, no reset so it
// maps onto block or distributed RAM.
module responder_regfile
  import cmd_fifo_responder_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic                   re,
  input  logic [AW-1:0]          addr,
  input  logic [DATA_MSB:DATA_LSB] wdata,
  output logic [DATA_MSB:DATA_LSB] rdata
);

  logic [DATA_MSB:DATA_LSB] mem [2**AW];

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cmd_fifo_responder.sv
// Pops 17-bit commands, executes them against a local byte register file and
// pushes 8-bit results into the response FIFO.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a command; pop strobe = !empty (once armed)
//   FETCH | FIFO read data valid; latch op/addr/wdata
//   EXEC  | range check, RAM write or read issue, counters update
//   RESP  | present response byte; push once the response FIFO has room
module cmd_fifo_responder
  import cmd_fifo_responder_pkg::*;
#(
  parameter int         MEM_DEPTH  = 256,
  parameter bit         ACK_WRITES = 1'b0,
  parameter logic [7:0] ACK_BYTE   = 8'hA5,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmd_fifo_responder_if.master bus,
  output logic                 busy,
  output logic [15:0]          cmd_count,
  output logic [7:0]           err_count
);

  localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

  state_e     state_q, state_d;
  resp_sel_e  rsel_q, rsel_d;
  logic       armed_q;
  logic       op_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] last_resp_q;
  logic [7:0] ram_rdata;
  logic [7:0] resp_byte;
  logic       in_range;
  logic       exec_cyc;
  logic       ram_we;
  logic       ram_re;
  logic       pop;
  logic       push;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign exec_cyc = (state_q == EXEC);
  assign ram_we   = exec_cyc && in_range && (op_q == OP_WRITE);
  assign ram_re   = exec_cyc && in_range && (op_q == OP_READ);

  responder_regfile #(.AW(AW)) u_regfile (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state and handshake strobes; pop and push are combinational so
  // that each command costs only one pop and full blocks the push directly.
  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    pop     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !bus.cmd_fifo_empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (!in_range) begin
          rsel_d  = RSEL_ERR;
          state_d = ((op_q == OP_READ) || ACK_WRITES) ? RESP : IDLE;
        end else if (op_q == OP_WRITE) begin
          rsel_d  = RSEL_ACK;
          state_d = ACK_WRITES ? RESP : IDLE;
        end else begin
          rsel_d  = RSEL_RDATA;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!bus.resp_fifo_full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response byte select; read data comes straight from the RAM register,
  // which holds still while the FSM waits in RESP.
  always_comb begin
    resp_byte = ram_rdata;
    unique case (rsel_q)
      RSEL_ACK: resp_byte = ACK_BYTE;
      RSEL_ERR: resp_byte = ERR_BYTE;
      default:  resp_byte = ram_rdata;
    endcase
  end

  assign bus.cmd_fifo_rd_en  = pop;
  assign bus.resp_fifo_wr_en = push;
  assign bus.resp_fifo_data  = (state_q == RESP) ? resp_byte : last_resp_q;
  assign busy                = (state_q != IDLE);

  // State, command latch, counters and last-pushed byte. armed_q keeps the
  // pop strobe low while reset is held, so no command is lost during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsel_q      <= RSEL_RDATA;
      armed_q     <= 1'b0;
      op_q        <= OP_READ;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      last_resp_q <= 8'h00;
      cmd_count   <= 16'h0000;
      err_count   <= 8'h00;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      armed_q <= 1'b1;
      if (state_q == FETCH) begin
        op_q    <= bus.cmd_fifo_data[OP_BIT];
        addr_q  <= bus.cmd_fifo_data[ADDR_MSB:ADDR_LSB];
        wdata_q <= bus.cmd_fifo_data[DATA_MSB:DATA_LSB];
      end
      if (exec_cyc) begin
        cmd_count <= cmd_count + 16'd1;
        if (!in_range) err_count <= sat_inc8(err_count);
      end
      if (push) last_resp_q <= resp_byte;
    end
  end

endmodule

// File: tb/tb_cmd_fifo_responder.sv
// Scoreboard bench: three responders (default, acked writes, 16-byte depth)
// driven from behavioural FIFO models sharing one clock.
module tb_cmd_fifo_responder;
  import cmd_fifo_responder_pkg::*;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NDUT];
  logic        full_r    [NDUT];
  logic [16:0] cmd_dout  [NDUT];
  logic        cmd_empty [NDUT];
  logic        rd_en_w   [NDUT];
  logic        wr_en_w   [NDUT];
  logic        busy_w    [NDUT];
  logic [7:0]  resp_w    [NDUT];
  logic [7:0]  err_w     [NDUT];
  logic [15:0] cnt_w     [NDUT];

  logic [16:0] cmd_q [NDUT][$];
  logic [7:0]  exp_q [NDUT][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit log_en = 1'b0;
  int pop_cyc[$];

  for (genvar k = 0; k < NDUT; k++) begin : g
    localparam int DEPTH = (k == 2) ? 16 : 256;
    localparam bit ACK   = (k == 1);
    cmd_fifo_responder_if ifc ();
    assign ifc.cmd_fifo_data  = cmd_dout[k];
    assign ifc.cmd_fifo_empty = cmd_empty[k];
    assign ifc.resp_fifo_full = full_r[k];
    assign rd_en_w[k]         = ifc.cmd_fifo_rd_en;
    assign wr_en_w[k]         = ifc.resp_fifo_wr_en;
    assign resp_w[k]          = ifc.resp_fifo_data;
    cmd_fifo_responder #(
      .MEM_DEPTH  (DEPTH),
      .ACK_WRITES (ACK),
      .ACK_BYTE   (8'hA5),
      .ERR_BYTE   (8'hEE)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n[k]),
      .bus       (ifc),
      .busy      (busy_w[k]),
      .cmd_count (cnt_w[k]),
      .err_count (err_w[k])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Command FIFO models: registered read, data valid the cycle after rd_en.
  initial begin
    for (int k = 0; k < NDUT; k++) begin
      cmd_empty[k] <= 1'b1;
      cmd_dout[k]  <= '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rd_en_w[k] && cmd_q[k].size() > 0) cmd_dout[k] <= cmd_q[k].pop_front();
        cmd_empty[k] <= (cmd_q[k].size() == 0);
      end
    end
  end

  // Monitor: handshake rules and scoreboard compare of every pushed byte.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < NDUT; k++) begin
        if (rd_en_w[k]) begin
          check($sformatf("pop_while_busy_dut%0d", k), busy_w[k], 1'b0);
          check($sformatf("pop_while_empty_dut%0d", k), cmd_empty[k], 1'b0);
          if (k == 0 && log_en) pop_cyc.push_back(cyc);
        end
        if (wr_en_w[k]) begin
          check($sformatf("push_while_full_dut%0d", k), full_r[k], 1'b0);
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_push_dut%0d: got 0x%0h, expected no push", k, resp_w[k]);
          end else begin
            check($sformatf("resp_dut%0d", k), resp_w[k], exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic push_cmd(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
    cmd_q[k].push_back({wr, a, d});
  endtask

  task automatic wait_rd_en(input int k);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_en_w[k]) seen = 1'b1;
    end
    check($sformatf("rd_en_timeout_dut%0d", k), seen, 1'b1);
  endtask

  task automatic wait_idle(input int k);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cmd_q[k].size() == 0 && exp_q[k].size() == 0 && !busy_w[k] && cmd_empty[k])
        done = 1'b1;
    end
    check($sformatf("idle_timeout_dut%0d", k), done, 1'b1);
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check($sformatf("%s_rd_en_dut%0d", tag, k), rd_en_w[k], 1'b0);
    check($sformatf("%s_wr_en_dut%0d", tag, k), wr_en_w[k], 1'b0);
    check($sformatf("%s_resp_data_dut%0d", tag, k), resp_w[k], 8'h00);
    check($sformatf("%s_busy_dut%0d", tag, k), busy_w[k], 1'b0);
    check($sformatf("%s_cmd_count_dut%0d", tag, k), cnt_w[k], 16'h0000);
    check($sformatf("%s_err_count_dut%0d", tag, k), err_w[k], 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst_n[k]  = 1'b0;
      full_r[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) check_reset_outputs(k, "por");
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;

    // Write then read back, no write acks.
    @(posedge clk); #1;
    push_cmd(0, OP_WRITE, 8'h10, 8'h5C);
    push_cmd(0, OP_READ, 8'h10, 8'h00);
    exp_q[0].push_back(8'h5C);
    wait_idle(0);
    check("wr_rd_cmd_count", cnt_w[0], 16'd2);
    check("wr_rd_err_count", err_w[0], 8'd0);

    // Acked write.
    @(posedge clk); #1;
    push_cmd(1, OP_WRITE, 8'h00, 8'hFF);
    exp_q[1].push_back(8'hA5);
    wait_idle(1);
    check("ack_cmd_count", cnt_w[1], 16'd1);
    check("ack_err_count", err_w[1], 8'd0);

    // Out of range on a 16-byte RAM; 0x20 aliases 0x00 in the low bits.
    @(posedge clk); #1;
    push_cmd(2, OP_WRITE, 8'h00, 8'h42);
    push_cmd(2, OP_WRITE, 8'h20, 8'h11);
    push_cmd(2, OP_READ, 8'h20, 8'h00);
    push_cmd(2, OP_READ, 8'h00, 8'h00);
    exp_q[2].push_back(8'hEE);
    exp_q[2].push_back(8'h42);
    wait_idle(2);
    check("oor_err_count", err_w[2], 8'd2);
    check("oor_cmd_count", cnt_w[2], 16'd4);

    // Back-pressure: response FIFO full for 5 cycles during a read.
    @(posedge clk); #1;
    push_cmd(0, OP_WRITE, 8'h30, 8'h3C);
    wait_idle(0);
    @(posedge clk); #1;
    full_r[0] = 1'b1;
    push_cmd(0, OP_READ, 8'h30, 8'h00);
    push_cmd(0, OP_READ, 8'h10, 8'h00);
    exp_q[0].push_back(8'h3C);
    exp_q[0].push_back(8'h5C);
    wait_rd_en(0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_wr_en", wr_en_w[0], 1'b0);
      check("stall_data", resp_w[0], 8'h3C);
      check("stall_rd_en", rd_en_w[0], 1'b0);
      check("stall_busy", busy_w[0], 1'b1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    full_r[0] = 1'b0;
    @(negedge clk);
    check("release_wr_en", wr_en_w[0], 1'b1);
    check("release_data", resp_w[0], 8'h3C);
    wait_idle(0);
    check("bp_cmd_count", cnt_w[0], 16'd5);

    // Burst: preload 0..15 with i^0xA0, then 16 back-to-back reads.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) push_cmd(0, OP_WRITE, 8'(i), 8'(i) ^ 8'hA0);
    wait_idle(0);
    check("preload_cmd_count", cnt_w[0], 16'd21);
    pop_cyc.delete();
    log_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      push_cmd(0, OP_READ, 8'(i), 8'h00);
      exp_q[0].push_back(8'(i) ^ 8'hA0);
    end
    wait_idle(0);
    log_en = 1'b0;
    check("burst_cmd_count", cnt_w[0], 16'd37);
    check("burst_pop_count", pop_cyc.size(), 16);
    for (int i = 1; i < pop_cyc.size(); i++)
      check($sformatf("burst_pop_gap_%0d", i), pop_cyc[i] - pop_cyc[i-1], 4);

    // Reset during the EXEC cycle of a write must not commit it.
    @(posedge clk); #1;
    push_cmd(0, OP_WRITE, 8'h05, 8'h12);
    wait_idle(0);
    check("pre_rst_cmd_count", cnt_w[0], 16'd38);
    @(posedge clk); #1;
    push_cmd(0, OP_WRITE, 8'h05, 8'h77);
    wait_rd_en(0);
    @(posedge clk);
    @(posedge clk); #1;
    check("exec_busy_before_rst", busy_w[0], 1'b1);
    rst_n[0] = 1'b0;
    #1;
    check_reset_outputs(0, "midrst");
    @(posedge clk); #1;
    check_reset_outputs(0, "midrst_held");
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    push_cmd(0, OP_READ, 8'h05, 8'h00);
    exp_q[0].push_back(8'h12);
    wait_idle(0);
    check("post_rst_cmd_count", cnt_w[0], 16'd1);
    check("post_rst_err_count", err_w[0], 8'd0);

    repeat (4) @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("leftover_expected_dut%0d", k), exp_q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_fifo_responder.md
# cmd_fifo_responder

Command-side responder for the 17-bit master command protocol. Pops commands from the command FIFO read port, executes each against an internal byte-wide register file, and pushes 8-bit results into the response FIFO write port. It sits entirely in the memory-side clock domain. It is a self-contained target for exercising the master and both async FIFOs without the BRAM path.

## Interface
Parameters:
- MEM_DEPTH, 256: number of implemented byte locations, 1..256; addresses >= MEM_DEPTH are out of range.
- ACK_WRITES, 0: 1 = every write also returns one response byte.
- ACK_BYTE, 8'hA5: response byte for an in-range write when ACK_WRITES=1.
- ERR_BYTE, 8'hEE: response byte for any out-of-range read, or out-of-range write when ACK_WRITES=1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_fifo_rd_en  out  1  pop request to command FIFO.
- cmd_fifo_data  in  17  [16] op (1 = write, 0 = read), [15:8] address, [7:0] write data.
- cmd_fifo_empty  in  1  command FIFO empty.
- resp_fifo_wr_en  out  1  push strobe to response FIFO.
- resp_fifo_data  out  8  response byte.
- resp_fifo_full  in  1  response FIFO full.
- busy  out  1  high whenever state != IDLE.
- cmd_count  out  16  commands executed; wraps 0xFFFF -> 0x0000.
- err_count  out  8  out-of-range commands; saturates at 0xFF.

## Operation
The block runs a single state machine: IDLE -> FETCH -> EXEC -> (RESP | IDLE).

- **IDLE:**
  - cmd_fifo_rd_en = !cmd_fifo_empty, combinational, and only in IDLE.
  - When it is asserted, go to FETCH.
- **FETCH:**
  - The FIFO read is registered, so cmd_fifo_data is valid in this cycle.
  - Latch op, addr and wdata. Go to EXEC.
- **EXEC, in-range write:**
  - mem[addr] <= wdata.
  - cmd_count++.
  - Go to RESP if ACK_WRITES, else go to IDLE.
- **EXEC, in-range read:**
  - Issue a synchronous read of mem[addr].
  - cmd_count++.
  - Go to RESP.
- **EXEC, out-of-range:**
  - No memory access.
  - cmd_count++ and err_count++ (saturating).
  - Go to RESP if the command is a read or ACK_WRITES=1, else go to IDLE.
- **RESP:**
  - While resp_fifo_full, hold with resp_fifo_wr_en=0 and resp_fifo_data stable.
  - When not full, assert resp_fifo_wr_en for exactly one cycle with the selected byte (read data / ACK_BYTE / ERR_BYTE). Go to IDLE.
- Ordering: commands execute strictly in order, so read-after-write to the same address returns the new data.
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: cmd_fifo_rd_en=0, resp_fifo_wr_en=0, resp_fifo_data=8'h00, busy=0, cmd_count=0, err_count=0, state=IDLE.
- Cycle numbering: cycle 0 is the rd_en cycle.
  - Read: FETCH at 1, EXEC at 2, resp_fifo_wr_en at cycle 3 if not full.
  - Write without ack: memory updated at the end of cycle 2; back in IDLE at cycle 3.
- Throughput:
  - 3 cycles per un-acked write.
  - 4 cycles per read or acked write.
  - Each full-stall cycle in RESP adds one cycle.
- Boundary conditions:
  - At most one rd_en per command. Never pop while busy.
  - cmd_fifo_empty is ignored outside IDLE.
  - resp_fifo_wr_en is never asserted while resp_fifo_full is high.
  - Empty asserting in the same cycle the FSM returns to IDLE gives no pop.
  - Reset asserted mid-command returns the FSM to IDLE immediately. The in-flight command is discarded and no partial response is pushed; a write whose EXEC edge had not yet occurred is not committed.

## Structure
- Shared package holds:
  - state encoding (IDLE, FETCH, EXEC, RESP);
  - command field constants: OP_BIT=16, ADDR_MSB=15, ADDR_LSB=8, DATA_MSB=7, DATA_LSB=0;
  - op codes OP_READ=0, OP_WRITE=1.
- One sub-module: responder_regfile, a single-port MEM_DEPTH x 8 RAM with synchronous write and registered read, inferable as block or distributed RAM.
- The FSM, counters and response mux stay in the top module.

## Test plan
- **Write then read:** after reset, push write(0x10, 0x5C) then read(0x10), ACK_WRITES=0 -> exactly one response 0x5C; cmd_count=2; err_count=0.
- **Acked write:** ACK_WRITES=1; push write(0x00, 0xFF) -> one response 0xA5.
- **Out of range:** MEM_DEPTH=16; push write(0x20, 0x11) then read(0x20) -> one response 0xEE; err_count=2; location 0x00 unchanged.
- **Back-pressure:** hold resp_fifo_full=1 for 5 cycles during a read of a location holding 0x3C -> wr_en stays 0 with data stable; single push of 0x3C one cycle after full drops; no further rd_en during the stall.
- **Reset mid-command:**
  - Assert rst_n=0 in the EXEC cycle of write(0x05, 0x77), where 0x05 previously held 0x12.
  - Required: all outputs return to reset values asynchronously.
  - Required: a later read(0x05) returns 0x12.
- **Burst:** 16 back-to-back reads of addresses 0..15 pre-loaded with i ^ 0xA0 -> 16 responses in order; cmd_count increments by 16; pops spaced exactly 4 cycles apart.
